// File: rtl/irq_pkg.sv
// irq_pkg: shared widths and FSM encoding for the irq pending latch.
package irq_pkg;
  localparam int N_REQ_DEF = 8;
  localparam int IDX_W_DEF = 3;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFER  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;
endpackage

// File: rtl/irq_edge_det.sv
// irq_edge_det: per-line rising-edge detector with a registered copy of the inputs.
module irq_edge_det #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] irq_in,
  output logic [N-1:0] rise
);
  logic [N-1:0] r_irq_q;
  always_ff @(posedge clk) begin
    if (!rst_n) r_irq_q <= '0;
    else        r_irq_q <= irq_in;
  end
  assign rise = irq_in & ~r_irq_q;
endmodule

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: latches requests, offers them one at a time to a priority encoder via valid/ack.
// IRQ_EDGE_DETECT_EN selects rising-edge request capture; level capture otherwise.
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] irq_in,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] pend_o,
  input  logic [IDX_W-1:0] irq_idx_in,
  output logic             irq_valid,
  input  logic             irq_ack,
  output logic [N_REQ-1:0] ovr_o,
  input  logic             ovr_clr
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_REQ-1:0] r_pend;
  logic [N_REQ-1:0] r_ovr;
  logic [N_REQ-1:0] w_set;
  logic [N_REQ-1:0] w_clr;
  logic [N_REQ-1:0] w_ovr_new;
  logic             w_any;
`ifdef IRQ_EDGE_DETECT_EN
  irq_edge_det #(.N(N_REQ)) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_in (irq_in),
    .rise   (w_set)
  );
`else
  assign w_set = irq_in;
`endif
  assign pend_o    = r_pend & mask & {N_REQ{en}};
  assign w_any     = |pend_o;
  assign irq_valid = r_state == ST_OFFER;
  assign w_clr     = (irq_valid && irq_ack) ? (N_REQ'(1) << irq_idx_in) : '0;
  // a set on a bit being cleared this cycle is a re-arm, not an overrun
  assign w_ovr_new = w_set & r_pend & ~w_clr;
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_any ? ST_OFFER : ST_IDLE;
      ST_OFFER: w_state_nxt = irq_ack ? ST_SETTLE : (w_any ? ST_OFFER : ST_IDLE);
      default:  w_state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_ovr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= (r_pend & ~w_clr) | w_set;
      r_ovr   <= (ovr_clr ? '0 : r_ovr) | w_ovr_new;
    end
  end
  assign ovr_o = r_ovr;
endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: directed checks of the pending latch with a behavioural 8:1 priority encoder on y.
module tb_irq_pending_latch;
  logic       clk = 0;
  logic       rst_n, en, irq_ack, ovr_clr, irq_valid;
  logic [7:0] irq_in, mask, pend_o, ovr_o;
  logic [2:0] w_idx;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  irq_pending_latch dut (
    .clk(clk), .rst_n(rst_n), .en(en), .irq_in(irq_in), .mask(mask), .pend_o(pend_o),
    .irq_idx_in(w_idx), .irq_valid(irq_valid), .irq_ack(irq_ack), .ovr_o(ovr_o), .ovr_clr(ovr_clr)
  );
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < 8; i++) if (pend_o[i]) w_idx = 3'(i);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0; en = 1; mask = 8'hFF; irq_in = 8'hFF; irq_ack = 0; ovr_clr = 0;
    tick(); tick();
    checks++; if (pend_o !== 8'h00) begin failures++; $display("FAIL reset_pend got=%h exp=00", pend_o); end
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", irq_valid); end
    checks++; if (ovr_o !== 8'h00) begin failures++; $display("FAIL reset_ovr got=%h exp=00", ovr_o); end
    rst_n = 1; irq_in = 8'h00;
    tick(); tick();
    checks++; if (pend_o !== 8'h00 || irq_valid !== 1'b0) begin failures++; $display("FAIL reset_release got=%h/%b exp=00/0", pend_o, irq_valid); end
  endtask
  task automatic test_single();
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    checks++; if (pend_o !== 8'h08 || irq_valid !== 1'b0) begin failures++; $display("FAIL single_k1 got=%h/%b exp=08/0", pend_o, irq_valid); end
    tick();
    checks++; if (irq_valid !== 1'b1 || w_idx !== 3'd3) begin failures++; $display("FAIL single_k2 got=%b/%0d exp=1/3", irq_valid, w_idx); end
    irq_ack = 1;
    tick();
    irq_ack = 0;
    checks++; if (pend_o !== 8'h00 || irq_valid !== 1'b0) begin failures++; $display("FAIL single_settle got=%h/%b exp=00/0", pend_o, irq_valid); end
    tick();
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", irq_valid); end
  endtask
  task automatic test_priority();
    logic [7:0] pv [3] = '{8'h91, 8'h11, 8'h01};
    logic [7:0] nv [3] = '{8'h11, 8'h01, 8'h00};
    logic [2:0] iv [3] = '{3'd7, 3'd4, 3'd0};
    irq_in = 8'h91;
    tick();
    irq_in = 8'h00;
    tick();
    for (int s = 0; s < 3; s++) begin
      checks++; if (irq_valid !== 1'b1 || pend_o !== pv[s] || w_idx !== iv[s]) begin failures++; $display("FAIL prio_offer%0d got=%b/%h/%0d exp=1/%h/%0d", s, irq_valid, pend_o, w_idx, pv[s], iv[s]); end
      irq_ack = 1;
      tick();
      irq_ack = 0;
      checks++; if (irq_valid !== 1'b0 || pend_o !== nv[s]) begin failures++; $display("FAIL prio_settle%0d got=%b/%h exp=0/%h", s, irq_valid, pend_o, nv[s]); end
      tick();
      checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL prio_idle%0d got=%b exp=0", s, irq_valid); end
      tick();
    end
  endtask
  task automatic test_mask_en();
    mask = 8'hDF; irq_in = 8'h20;
    tick();
    irq_in = 8'h00;
    checks++; if (pend_o !== 8'h00) begin failures++; $display("FAIL mask_pend got=%h exp=00", pend_o); end
    irq_ack = 1;
    tick(); tick();
    irq_ack = 0;
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL mask_valid got=%b exp=0", irq_valid); end
    mask = 8'hFF;
    #1;
    checks++; if (pend_o !== 8'h20) begin failures++; $display("FAIL unmask_pend got=%h exp=20", pend_o); end
    tick();
    checks++; if (irq_valid !== 1'b1 || w_idx !== 3'd5) begin failures++; $display("FAIL unmask_offer got=%b/%0d exp=1/5", irq_valid, w_idx); end
    en = 0;
    tick();
    checks++; if (irq_valid !== 1'b0 || pend_o !== 8'h00) begin failures++; $display("FAIL en_drop got=%b/%h exp=0/00", irq_valid, pend_o); end
    en = 1;
    #1;
    checks++; if (pend_o !== 8'h20) begin failures++; $display("FAIL en_retained got=%h exp=20", pend_o); end
    tick();
    irq_ack = 1;
    tick();
    irq_ack = 0;
    checks++; if (pend_o !== 8'h00) begin failures++; $display("FAIL mask_clear got=%h exp=00", pend_o); end
    tick();
  endtask
  task automatic test_overrun();
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    tick();
    irq_ack = 1; irq_in = 8'h04;
    tick();
    irq_ack = 0; irq_in = 8'h00;
    checks++; if (pend_o !== 8'h04 || ovr_o !== 8'h00) begin failures++; $display("FAIL collision got=%h/%h exp=04/00", pend_o, ovr_o); end
    tick(); tick();
    checks++; if (irq_valid !== 1'b1) begin failures++; $display("FAIL collision_reoffer got=%b exp=1", irq_valid); end
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    checks++; if (ovr_o !== 8'h04 || pend_o !== 8'h04) begin failures++; $display("FAIL overrun got=%h/%h exp=04/04", ovr_o, pend_o); end
    ovr_clr = 1;
    tick();
    ovr_clr = 0;
    checks++; if (ovr_o !== 8'h00) begin failures++; $display("FAIL ovr_clr got=%h exp=00", ovr_o); end
    irq_ack = 1;
    tick();
    irq_ack = 0;
    tick();
    checks++; if (pend_o !== 8'h00 || irq_valid !== 1'b0) begin failures++; $display("FAIL overrun_drain got=%h/%b exp=00/0", pend_o, irq_valid); end
  endtask
  task automatic test_mode();
    int services = 0;
`ifdef IRQ_EDGE_DETECT_EN
    int exp_services = 1;
`else
    int exp_services = 4;
`endif
    for (int t = 0; t < 20; t++) begin
      irq_in = (t < 10) ? 8'h02 : 8'h00;
      irq_ack = irq_valid;
      if (irq_valid) services++;
      tick();
    end
    irq_ack = 0;
    checks++; if (services !== exp_services) begin failures++; $display("FAIL mode_services got=%0d exp=%0d", services, exp_services); end
    checks++; if (pend_o !== 8'h00) begin failures++; $display("FAIL mode_drain got=%h exp=00", pend_o); end
  endtask
  task automatic test_reset_offer();
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick();
    checks++; if (irq_valid !== 1'b1) begin failures++; $display("FAIL rst_offer_pre got=%b exp=1", irq_valid); end
    rst_n = 0; irq_ack = 1;
    tick();
    rst_n = 1; irq_ack = 0;
    checks++; if (pend_o !== 8'h00 || irq_valid !== 1'b0 || ovr_o !== 8'h00) begin failures++; $display("FAIL rst_offer got=%h/%b/%h exp=00/0/00", pend_o, irq_valid, ovr_o); end
    tick();
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL rst_offer_after got=%b exp=0", irq_valid); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask_en();
    test_overrun();
    test_mode();
    test_reset_offer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
